// File: rtl/sb_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sb_axi_pkg
// Description : Shared response codes, engine state encodings and response
//               selection for the sb_axi memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package sb_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // A decode error outranks a slave error.
    function automatic logic [1:0] axi_resp_sel(input logic dec_err, input logic slv_err);
        if (dec_err)
            return AXI_RESP_DECERR;
        else if (slv_err)
            return AXI_RESP_SLVERR;
        else
            return AXI_RESP_OKAY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_axi_mem_bank.sv
`default_nettype none
// ============================================================================
// Module      : sb_axi_mem_bank
// Description : DEPTH x DATA_WIDTH storage with one byte-enabled write port
//               and one registered read port (read returns pre-write data).
// Revision    : 1.0 - initial release
// ============================================================================
module sb_axi_mem_bank #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_WIDTH/8-1:0]    i_wstrb,
    input  logic [DATA_WIDTH-1:0]      i_wdata,
    input  logic                       i_re,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [DATA_WIDTH-1:0]      o_rdata
);

    localparam int c_NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < c_NBYTES; b++) begin
                if (i_wstrb[b])
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    // Only the output register is reset; the array itself keeps its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rdata <= '0;
        else if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sb_axi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : sb_axi_mem_responder
// Description : AXI4 INCR-only subordinate serving write and read bursts from
//               an internal byte-enabled memory; independent engines.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_axi_mem_responder
    import sb_axi_pkg::*;
#(
    parameter int                    ID_WIDTH   = 16,
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 512,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [ID_WIDTH-1:0]       s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,

    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,

    output logic [ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,

    input  logic [ID_WIDTH-1:0]       s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,

    output logic [ID_WIDTH-1:0]       s_axi_rid,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int                    c_LG     = $clog2(DATA_WIDTH / 8);
    localparam int                    c_MEM_AW = $clog2(DEPTH);
    localparam logic [2:0]            c_SIZE   = 3'(c_LG);
    localparam logic [ADDR_WIDTH-1:0] c_DEPTH  = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_ONE    = ADDR_WIDTH'(1);

    // ---------------- write engine ----------------
    wr_state_e               r_wstate;
    logic                    r_awready;
    logic                    r_wready;
    logic                    r_bvalid;
    logic [ID_WIDTH-1:0]     r_bid;
    logic [1:0]              r_bresp;
    logic [ID_WIDTH-1:0]     r_wid;
    logic [ADDR_WIDTH-1:0]   r_waddr;
    logic [7:0]              r_wcnt;
    logic                    r_wsize_err;
    logic                    r_wproto_err;
    logic                    r_wdec_err;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic [ADDR_WIDTH-1:0]   w_aw_word;
    logic                    w_w_inrange;
    logic                    w_mem_we;
    logic                    w_wdec_next;
    logic                    w_wproto_next;

    assign w_aw_hs     = r_awready & s_axi_awvalid;
    assign w_w_hs      = r_wready & s_axi_wvalid;
    assign w_aw_word   = (s_axi_awaddr - BASE_ADDR) >> c_LG;
    assign w_w_inrange = (r_waddr < c_DEPTH);
    assign w_mem_we    = w_w_hs & w_w_inrange & ~r_wsize_err;
    assign w_wdec_next = r_wdec_err | ~w_w_inrange;
    // wlast must coincide exactly with the last counted beat.
    assign w_wproto_next = r_wproto_err |
                           (s_axi_wlast ? (r_wcnt != 8'd0) : (r_wcnt == 8'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate     <= W_IDLE;
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bid        <= '0;
            r_bresp      <= AXI_RESP_OKAY;
            r_wid        <= '0;
            r_waddr      <= '0;
            r_wcnt       <= 8'd0;
            r_wsize_err  <= 1'b0;
            r_wproto_err <= 1'b0;
            r_wdec_err   <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awready    <= 1'b0;
                        r_wready     <= 1'b1;
                        r_wid        <= s_axi_awid;
                        r_waddr      <= w_aw_word;
                        r_wcnt       <= s_axi_awlen;
                        r_wsize_err  <= (s_axi_awsize != c_SIZE);
                        r_wproto_err <= 1'b0;
                        r_wdec_err   <= 1'b0;
                        r_wstate     <= W_DATA;
                    end else begin
                        r_awready    <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_waddr      <= r_waddr + c_ONE;
                        r_wcnt       <= r_wcnt - 8'd1;
                        r_wdec_err   <= w_wdec_next;
                        r_wproto_err <= w_wproto_next;
                        if (s_axi_wlast) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_wid;
                            r_bresp  <= axi_resp_sel(w_wdec_next, r_wsize_err | w_wproto_next);
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- read engine ----------------
    rd_state_e               r_rstate;
    logic                    r_arready;
    logic                    r_rvalid;
    logic                    r_rlast;
    logic [1:0]              r_rresp;
    logic                    r_rzero;
    logic [ID_WIDTH-1:0]     r_rid;
    logic [ADDR_WIDTH-1:0]   r_raddr;
    logic [7:0]              r_rcnt;
    logic                    r_rsize_err;

    logic                    w_ar_hs;
    logic                    w_r_hs;
    logic                    w_rd_fetch;
    logic [ADDR_WIDTH-1:0]   w_rd_word;
    logic                    w_rd_size_err;
    logic [1:0]              w_rd_resp;
    logic [DATA_WIDTH-1:0]   w_bank_rdata;

    assign w_ar_hs       = r_arready & s_axi_arvalid;
    assign w_r_hs        = r_rvalid & s_axi_rready;
    // Next word is fetched on the accepting edge so it is ready one cycle later.
    assign w_rd_fetch    = w_ar_hs | (w_r_hs & ~r_rlast);
    assign w_rd_word     = w_ar_hs ? ((s_axi_araddr - BASE_ADDR) >> c_LG) : (r_raddr + c_ONE);
    assign w_rd_size_err = w_ar_hs ? (s_axi_arsize != c_SIZE) : r_rsize_err;
    assign w_rd_resp     = axi_resp_sel(w_rd_word >= c_DEPTH, w_rd_size_err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate    <= R_IDLE;
            r_arready   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_rresp     <= AXI_RESP_OKAY;
            r_rzero     <= 1'b0;
            r_rid       <= '0;
            r_raddr     <= '0;
            r_rcnt      <= 8'd0;
            r_rsize_err <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready   <= 1'b0;
                        r_rid       <= s_axi_arid;
                        r_raddr     <= w_rd_word;
                        r_rcnt      <= s_axi_arlen;
                        r_rsize_err <= w_rd_size_err;
                        r_rvalid    <= 1'b1;
                        r_rlast     <= (s_axi_arlen == 8'd0);
                        r_rresp     <= w_rd_resp;
                        r_rzero     <= (w_rd_resp != AXI_RESP_OKAY);
                        r_rstate    <= R_DATA;
                    end else begin
                        r_arready   <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_raddr   <= w_rd_word;
                            r_rcnt    <= r_rcnt - 8'd1;
                            r_rlast   <= (r_rcnt == 8'd1);
                            r_rresp   <= w_rd_resp;
                            r_rzero   <= (w_rd_resp != AXI_RESP_OKAY);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    sb_axi_mem_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_mem_we),
        .i_waddr (r_waddr[c_MEM_AW-1:0]),
        .i_wstrb (s_axi_wstrb),
        .i_wdata (s_axi_wdata),
        .i_re    (w_rd_fetch),
        .i_raddr (w_rd_word[c_MEM_AW-1:0]),
        .o_rdata (w_bank_rdata)
    );

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bid     = r_bid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rid     = r_rid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rdata   = r_rzero ? '0 : w_bank_rdata;

endmodule
`default_nettype wire

// File: doc/sb_axi_mem_responder.md
Name: sb_axi_mem_responder

Overview:
- AXI4 subordinate that answers the 512-bit manager port of the FPGA queue subsystem.
- Serves write and read bursts from an internal byte-enabled memory.
- Used as the host-memory model in simulation, and as an on-card scratch memory behind the queue crossbar.
- Independent write and read engines; one outstanding burst per direction.

Parameters:
ID_WIDTH, 16, width of all ID fields
ADDR_WIDTH, 64, byte address width
DATA_WIDTH, 512, data bus width in bits (power of two, >=32)
DEPTH, 1024, memory size in DATA_WIDTH words
BASE_ADDR, 0, byte address of word 0

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_axi_awid  in  ID_WIDTH  write burst ID
s_axi_awaddr  in  ADDR_WIDTH  write start byte address
s_axi_awlen  in  8  beats minus one
s_axi_awsize  in  3  beat size, log2 bytes
s_axi_awvalid/s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  final write beat
s_axi_wvalid/s_axi_wready  in/out  1  W handshake
s_axi_bid  out  ID_WIDTH  response ID
s_axi_bresp  out  2  write response
s_axi_bvalid/s_axi_bready  out/in  1  B handshake
s_axi_arid  in  ID_WIDTH  read burst ID
s_axi_araddr  in  ADDR_WIDTH  read start byte address
s_axi_arlen  in  8  beats minus one
s_axi_arsize  in  3  beat size
s_axi_arvalid/s_axi_arready  in/out  1  AR handshake
s_axi_rid  out  ID_WIDTH  read ID
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  per-beat read response
s_axi_rlast  out  1  final read beat
s_axi_rvalid/s_axi_rready  out/in  1  R handshake

Behaviour:
- Reset: clk is the single clock; rst is asynchronous, active-high. During rst, awready, arready, wready, bvalid and rvalid are 0; bid, bresp, rid, rdata, rresp and rlast are 0. Memory contents are not reset.
- Burst type: INCR only; no burst port exists. Word address = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8); low address bits are ignored.
- Addresses increment linearly; 4 KB crossings are not checked.
- Write FSM:
  - W_IDLE: awready=1. AW handshake captures id, word address, beat count=awlen and a size_err flag (awsize != log2(DATA_WIDTH/8)); goes to W_DATA next cycle.
  - W_DATA: wready=1. Each handshake writes the bytes selected by wstrb, unless size_err is set or the word is >= DEPTH. Address increments and the count decrements.
  - A beat with wlast=1 goes to W_RESP. wlast asserted early, or absent on the last counted beat, sets a sticky protocol error; the burst ends only at wlast.
  - W_RESP: bvalid=1 and bid=captured id, held until bready, then W_IDLE.
  - bresp priority: DECERR(2'b11) if any beat was out of range, else SLVERR(2'b10) for size or protocol error, else OKAY.
- Read FSM:
  - R_IDLE: arready=1. AR handshake captures the burst and goes to R_DATA; the first beat (rvalid=1) is presented the cycle after the handshake.
  - Each R handshake presents the next word the following cycle, so back-to-back beats give full throughput. rlast=1 on beat awlen (arlen).
  - After the rlast handshake, return to R_IDLE; arready reasserts the next cycle.
  - Out-of-range beat: rdata=0, rresp=DECERR. Bad arsize: rdata=0, rresp=SLVERR on every beat.
  - rdata, rresp and rlast are stable while rvalid=1 and rready=0.
- Same-cycle read fetch and write to the same word: the read returns the old data.
- AW and AR may be accepted in the same cycle; the two engines never stall each other.
- awlen=0 / arlen=0: single beat; wlast/rlast on that beat.
- Reset mid-burst: the burst is abandoned with no B or R beats; memory writes already committed are kept.

Decomposition:
- Package sb_axi_pkg:
  - resp codes AXI_RESP_OKAY/SLVERR/DECERR
  - write state enum {W_IDLE,W_DATA,W_RESP}
  - read state enum {R_IDLE,R_DATA}
- Sub-module sb_axi_mem_bank: DEPTH x DATA_WIDTH array, one byte-enabled write port, one registered read port.

Test Plan:
- Write at 0x40, awlen=3, awsize=6, wstrb all ones, data 1..4 -> four beats accepted, bresp=OKAY, bid=0x0005 matches. Then read 0x40, arlen=3 -> rdata 1,2,3,4, rlast only on the 4th beat, rresp=OKAY.
- Single write with wstrb=0x...0001, data 0xAA, over a word preloaded to all ones -> read returns byte0=0xAA with all other bytes 0xFF.
- Write to word DEPTH (0x10000 for DEPTH=1024) -> bresp=DECERR and memory unchanged. Read of the same address -> rdata=0, rresp=DECERR.
- rready toggled 1,0,0,1 during a 4-beat read -> rdata held while stalled, no beats lost or duplicated.
- Concurrent 16-beat read and 16-beat write to disjoint regions, random valid/ready -> both complete with correct data, IDs and responses.
- rst asserted mid-write at beat 2 of 4 -> bvalid never asserted; after release, awready=1 and a new burst completes with OKAY.
